writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 114 +++++++++++
 tb/tb_writeback_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU and load results into one register-bank write per cycle.
// Optional macro WB_SCOREBOARD_EN adds pending-write hazard compare against rs/rt.
module writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [4:0]               alu_reg,
   input  logic [31:0]              alu_data,
   output logic                     alu_ready,
   input  logic                     mem_valid,
   input  logic [4:0]               mem_reg,
   input  logic [31:0]              mem_data,
   output logic                     mem_ready,
   input  logic                     wb_hold,
   output logic                     write_reg_flag,
   output logic [4:0]               write_reg,
   output logic [31:0]              write_data,
   input  logic [4:0]               rs,
   input  logic [4:0]               rt,
   output logic                     hazard_a,
   output logic                     hazard_b,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [4:0]    reg_q  [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   occ_q, occ_d;

   logic          full, empty;
   logic          mem_take, alu_take;
   logic          push, pop;
   logic [4:0]    push_reg;
   logic [31:0]   push_data;

   assign full      = (occ_q == FULL_CNT);
   assign empty     = (occ_q == '0);
   assign occupancy = occ_q;

   // Readiness comes only from the registered full flag: a pop never frees a slot same-cycle.
   assign mem_ready = ~full;
   assign alu_ready = ~full & ~mem_valid;

   always_comb begin
      mem_take  = mem_valid & mem_ready;
      alu_take  = alu_valid & alu_ready;
      push_reg  = mem_take ? mem_reg  : alu_reg;
      push_data = mem_take ? mem_data : alu_data;
      push      = (mem_take | alu_take) & (push_reg != 5'd0);
      pop       = ~empty & ~wb_hold;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      occ_d = occ_q + (AW+1)'(1);
      else if (!push && pop) occ_d = occ_q - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Entry storage needs no reset; validity is carried entirely by occ_q.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         reg_q[wr_ptr_q]  <= push_reg;
         data_q[wr_ptr_q] <= push_data;
      end
   end

   assign write_reg_flag = ~pop;
   assign write_reg      = pop ? reg_q[rd_ptr_q]  : 5'd0;
   assign write_data     = pop ? data_q[rd_ptr_q] : 32'd0;

`ifdef WB_SCOREBOARD_EN
   logic [AW-1:0] hz_idx;

   // The head being written this cycle still counts as pending.
   always_comb begin
      hazard_a = 1'b0;
      hazard_b = 1'b0;
      hz_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hz_idx = rd_ptr_q + AW'(i);
         if ((AW+1)'(i) < occ_q) begin
            if (rs != 5'd0 && reg_q[hz_idx] == rs) hazard_a = 1'b1;
            if (rt != 5'd0 && reg_q[hz_idx] == rt) hazard_b = 1'b1;
         end
      end
   end
`else
   logic unused_rs_rt;
   assign unused_rs_rt = ^{rs, rt};
   assign hazard_a     = 1'b0;
   assign hazard_b     = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed vector table, hazard sequence, and random traffic
// checked against a queue-based reference model.
module tb_writeback_queue;

   localparam int DEPTH = 4;
   localparam int OW    = $clog2(DEPTH) + 1;
`ifdef WB_SCOREBOARD_EN
   localparam bit HZ = 1'b1;
`else
   localparam bit HZ = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid, mem_valid, wb_hold;
   logic [4:0]    alu_reg, mem_reg, rs, rt;
   logic [31:0]   alu_data, mem_data;
   logic          alu_ready, mem_ready, write_reg_flag, hazard_a, hazard_b;
   logic [4:0]    write_reg;
   logic [31:0]   write_data;
   logic [OW-1:0] occupancy;

   writeback_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
      .wb_hold(wb_hold), .write_reg_flag(write_reg_flag), .write_reg(write_reg),
      .write_data(write_data), .rs(rs), .rt(rt), .hazard_a(hazard_a), .hazard_b(hazard_b),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   typedef struct {
      bit          rst, hold, av;
      logic [4:0]  ar;
      logic [31:0] ad;
      bit          mv;
      logic [4:0]  mr;
      logic [31:0] md;
      bit          ef;
      logic [4:0]  er;
      logic [31:0] ed;
      bit          ear, emr;
      int          eocc;
   } vec_t;

   ent_t q[$];
   vec_t tv[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One cycle against the reference model: check outputs, clock, update the model.
   task automatic model_step();
      bit   full, pop, ha, hb;
      ent_t head;
      full = (q.size() == DEPTH);
      pop  = (q.size() != 0) && !wb_hold;
      head = pop ? q[0] : '0;
      ha = 1'b0;
      hb = 1'b0;
      if (HZ) begin
         foreach (q[i]) begin
            if (rs != 0 && q[i].r == rs) ha = 1'b1;
            if (rt != 0 && q[i].r == rt) hb = 1'b1;
         end
      end
      #1;
      chk("m_mem_ready", mem_ready, !full);
      chk("m_alu_ready", alu_ready, !full && !mem_valid);
      chk("m_flag", write_reg_flag, !pop);
      chk("m_write_reg", write_reg, head.r);
      chk("m_write_data", write_data, head.d);
      chk("m_occupancy", occupancy, q.size());
      chk("m_hazard_a", hazard_a, ha);
      chk("m_hazard_b", hazard_b, hb);
      @(posedge clk);
      if (rst) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (mem_valid && !full) begin
            if (mem_reg != 0) q.push_back(ent_t'({mem_reg, mem_data}));
         end else if (alu_valid && !full) begin
            if (alu_reg != 0) q.push_back(ent_t'({alu_reg, alu_data}));
         end
      end
      #1;
   endtask

   initial begin
      // rst hold av ar ad mv mr md | flag reg data aready mready occ
      tv.push_back('{0,0,0, 0,0,          0,0,0,       1, 0,0,          1,1,0}); // reset state
      tv.push_back('{0,0,1, 8,32'h1234,   0,0,0,       1, 0,0,          1,1,0});
      tv.push_back('{0,0,0, 0,0,          0,0,0,       0, 8,32'h1234,   1,1,1});
      tv.push_back('{0,0,0, 0,0,          0,0,0,       1, 0,0,          1,1,0});
      tv.push_back('{0,0,1,10,32'hBB,     1,9,32'hAA,  1, 0,0,          0,1,0}); // mem wins
      tv.push_back('{0,0,1,10,32'hBB,     0,0,0,       0, 9,32'hAA,     1,1,1});
      tv.push_back('{0,0,0, 0,0,          0,0,0,       0,10,32'hBB,     1,1,1});
      tv.push_back('{0,0,0, 0,0,          0,0,0,       1, 0,0,          1,1,0});
      tv.push_back('{0,1,1, 1,1,          0,0,0,       1, 0,0,          1,1,0}); // fill under hold
      tv.push_back('{0,1,1, 2,2,          0,0,0,       1, 0,0,          1,1,1});
      tv.push_back('{0,1,1, 3,3,          0,0,0,       1, 0,0,          1,1,2});
      tv.push_back('{0,1,1, 4,4,          0,0,0,       1, 0,0,          1,1,3});
      tv.push_back('{0,1,1, 5,5,          0,0,0,       1, 0,0,          0,0,4}); // full stalls
      tv.push_back('{0,0,1, 5,5,          0,0,0,       0, 1,1,          0,0,4}); // no bypass
      tv.push_back('{0,0,1, 5,5,          0,0,0,       0, 2,2,          1,1,3});
      tv.push_back('{0,0,0, 0,0,          0,0,0,       0, 3,3,          1,1,3});
      tv.push_back('{0,0,0, 0,0,          0,0,0,       0, 4,4,          1,1,2});
      tv.push_back('{0,0,0, 0,0,          0,0,0,       0, 5,5,          1,1,1});
      tv.push_back('{0,0,0, 0,0,          0,0,0,       1, 0,0,          1,1,0});
      tv.push_back('{0,0,1, 0,32'hFFFF,   0,0,0,       1, 0,0,          1,1,0}); // r0 dropped
      tv.push_back('{0,0,0, 0,0,          0,0,0,       1, 0,0,          1,1,0});
      tv.push_back('{0,1,1, 1,32'h11,     0,0,0,       1, 0,0,          1,1,0});
      tv.push_back('{0,1,1, 2,32'h22,     0,0,0,       1, 0,0,          1,1,1});
      tv.push_back('{0,1,1, 3,32'h33,     0,0,0,       1, 0,0,          1,1,2});
      tv.push_back('{1,1,1, 4,32'h44,     0,0,0,       1, 0,0,          1,1,3}); // reset flushes
      tv.push_back('{0,0,0, 0,0,          0,0,0,       1, 0,0,          1,1,0});
      tv.push_back('{0,0,0, 0,0,          0,0,0,       1, 0,0,          1,1,0});
      tv.push_back('{0,1,1, 6,32'h66,     0,0,0,       1, 0,0,          1,1,0});
      tv.push_back('{0,1,1, 7,32'h77,     0,0,0,       1, 0,0,          1,1,1});
      tv.push_back('{1,0,0, 0,0,          0,0,0,       0, 6,32'h66,     1,1,2}); // reset mid-drain
      tv.push_back('{0,0,0, 0,0,          0,0,0,       1, 0,0,          1,1,0});

      rst = 1'b1; wb_hold = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
      alu_reg = '0; alu_data = '0; mem_reg = '0; mem_data = '0; rs = '0; rt = '0;
      repeat (2) @(posedge clk);
      #1;

      foreach (tv[k]) begin
         rst = tv[k].rst; wb_hold = tv[k].hold;
         alu_valid = tv[k].av; alu_reg = tv[k].ar; alu_data = tv[k].ad;
         mem_valid = tv[k].mv; mem_reg = tv[k].mr; mem_data = tv[k].md;
         #1;
         chk($sformatf("v%0d_flag", k),   write_reg_flag, tv[k].ef);
         chk($sformatf("v%0d_reg", k),    write_reg,      tv[k].er);
         chk($sformatf("v%0d_data", k),   write_data,     tv[k].ed);
         chk($sformatf("v%0d_aready", k), alu_ready,      tv[k].ear);
         chk($sformatf("v%0d_mready", k), mem_ready,      tv[k].emr);
         chk($sformatf("v%0d_occ", k),    occupancy,      tv[k].eocc);
         @(posedge clk);
         #1;
      end

      rst = 1'b0; wb_hold = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
      q.delete();

      // Hazard sequence: r11 pending, then drained, then rs = 0.
      wb_hold = 1'b1; alu_valid = 1'b1; alu_reg = 5'd11; alu_data = 32'hB0B;
      model_step();
      alu_valid = 1'b0; rs = 5'd11; rt = 5'd12;
      #1;
      chk("haz_a_pending", hazard_a, HZ);
      chk("haz_b_other", hazard_b, 0);
      model_step();
      wb_hold = 1'b0;
      #1;
      chk("haz_a_head_write", hazard_a, HZ);
      chk("flag_head_write", write_reg_flag, 0);
      model_step();
      #1;
      chk("haz_a_after_write", hazard_a, 0);
      wb_hold = 1'b1; alu_valid = 1'b1; alu_reg = 5'd11; rs = 5'd0; rt = 5'd11;
      model_step();
      alu_valid = 1'b0;
      #1;
      chk("haz_a_rs_zero", hazard_a, 0);
      chk("haz_b_pending", hazard_b, HZ);
      rst = 1'b1;
      model_step();
      rst = 1'b0; wb_hold = 1'b0;

      // Random traffic; producers hold an offer stable until it is accepted.
      for (int n = 0; n < 500; n++) begin
         bit m_acc, a_acc;
         rst     = ($urandom_range(0, 59) == 0);
         wb_hold = ($urandom_range(0, 2) == 0);
         if (!mem_valid) begin
            mem_valid = ($urandom_range(0, 2) == 0);
            mem_reg   = 5'($urandom_range(0, 7));
            mem_data  = $urandom;
         end
         if (!alu_valid) begin
            alu_valid = ($urandom_range(0, 1) == 0);
            alu_reg   = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
         end
         rs = 5'($urandom_range(0, 7));
         rt = 5'($urandom_range(0, 7));
         m_acc = mem_valid && (q.size() != DEPTH);
         a_acc = alu_valid && (q.size() != DEPTH) && !mem_valid;
         model_step();
         if (m_acc) mem_valid = 1'b0;
         if (a_acc) alu_valid = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
